// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and
// bit-timing helpers derived from the clock and line rates.
package uart_pkg;

  localparam int DEF_CLK_HZ = 10_000_000;
  localparam int DEF_BAUD   = 9600;

  // Receiver frame states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Width of the bit-period down-counter.
  function automatic int calc_cnt_w(input int clk_hz, input int baud);
    return $clog2(calc_bit_cyc(clk_hz, baud));
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous input pin, with a
// configurable reset level so idle-high lines come out of reset idle.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: pin -> r_meta -> r_sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the raw pin, samples mid-bit using a
// down-counter, and presents whole bytes through a single-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD
) (
  input  logic       clk_10,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BIT_CYC  = calc_bit_cyc(CLK_HZ, BAUD);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = calc_cnt_w(CLK_HZ, BAUD);

  // Counter reload values: the counter runs from LD down to 0 and the
  // sample is taken on the cycle it reads 0.
  localparam logic [CNT_W-1:0] C_HALF_LD = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] C_BIT_LD  = CNT_W'(BIT_CYC - 1);

  logic             w_rx_s;
  logic             r_rx_prev;
  logic             w_fall;
  logic             w_tick;

  rx_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit, w_bit_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             w_good;
  logic             w_ferr;

  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk   (clk_10),
    .rst_n (rst_n),
    .i_d   (uart_rx),
    .o_q   (w_rx_s)
  );

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) r_rx_prev <= 1'b1;
    else        r_rx_prev <= w_rx_s;
  end

  assign w_fall = r_rx_prev & ~w_rx_s;
  assign w_tick = (r_cnt == '0);

  // Frame FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  // Next-state logic: sampling happens only when the timer hits zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_tick ? r_cnt : r_cnt - CNT_W'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_good       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_cnt_next   = C_HALF_LD;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DATA;
            w_bit_next   = 3'd0;
            w_cnt_next   = C_BIT_LD;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_next = {w_rx_s, r_shift[7:1]};
          w_cnt_next   = C_BIT_LD;
          if (r_bit == 3'd7) w_state_next = ST_STOP;
          else               w_bit_next   = r_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          // Returning to IDLE right at the stop sample lets a
          // back-to-back start edge be caught even with baud skew.
          if (w_rx_s) begin
            w_good       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_rx_s) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Holding register: load on a good frame when empty or draining this
  // cycle, otherwise drop the new byte and flag overrun.
  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_good) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
